// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch unit.
//   fetch_state_t : sequencing state (IDLE, ARMED, RUN, HALT)
//   kJumpTarg     : absolute jump targets, indexed by decoder PCTarg
//   kBrOff        : 8-bit two's complement branch offsets, indexed by PCTarg
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   localparam int unsigned kJumpTarg [4] = '{0, 32, 64, 128};

   localparam logic signed [7:0] kBrOff [4] = '{8'sd2, 8'sd4, -8'sd4, -8'sd16};

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: handshake and sequencing bundle between the fetch unit, the
// control decoder / ALU, and the testbench.
//   Start, Stall, Jump, BranchEn, Zero, PCTarg, Ack : into the fetch unit
//   ProgCtr, Running, Done, CycleCt                 : out of the fetch unit
// Modports: master drives the inputs and observes outputs, slave is the fetch unit.
interface fetch_unit_if #(
   parameter int unsigned PC_W = 10,
   parameter int unsigned CT_W = 16
);
   logic            Start;
   logic            Stall;
   logic            Jump;
   logic            BranchEn;
   logic            Zero;
   logic [1:0]      PCTarg;
   logic            Ack;
   logic [PC_W-1:0] ProgCtr;
   logic            Running;
   logic            Done;
   logic [CT_W-1:0] CycleCt;

   modport master (
      output Start, Stall, Jump, BranchEn, Zero, PCTarg, Ack,
      input  ProgCtr, Running, Done, CycleCt
   );

   modport slave (
      input  Start, Stall, Jump, BranchEn, Zero, PCTarg, Ack,
      output ProgCtr, Running, Done, CycleCt
   );
endinterface

// File: rtl/fetch_unit_target_lut.sv
// target_lut: combinational decode of the decoder's PCTarg index.
//   pc_targ_i   : LUT index
//   jump_targ_o : absolute jump target, PC_W bits
//   br_off_o    : branch offset sign-extended to PC_W bits
// Kept as its own module so the table can be regenerated independently.
module target_lut
   import fetch_unit_pkg::*;
#(
   parameter int unsigned PC_W = 10
) (
   input  logic [1:0]      pc_targ_i,
   output logic [PC_W-1:0] jump_targ_o,
   output logic [PC_W-1:0] br_off_o
);

   always_comb begin
      jump_targ_o = PC_W'(kJumpTarg[pc_targ_i]);
      // kBrOff is signed, so the width cast sign-extends
      br_off_o    = PC_W'(kBrOff[pc_targ_i]);
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, Start/Done handshake and run-cycle counter.
//   Clk     : system clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : fetch_unit_if.slave (decoder inputs, Start/Stall in;
//             ProgCtr, Running, Done, CycleCt out)
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned PC_W = 10,
   parameter int unsigned CT_W = 16
) (
   input logic          Clk,
   input logic          Reset_n,
   fetch_unit_if.slave  bus
);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            done_q, done_d;
   logic [CT_W-1:0] ct_q, ct_d;
   logic [PC_W-1:0] jump_targ;
   logic [PC_W-1:0] br_off;
   logic            advance;

   target_lut #(
      .PC_W (PC_W)
   ) u_target_lut (
      .pc_targ_i   (bus.PCTarg),
      .jump_targ_o (jump_targ),
      .br_off_o    (br_off)
   );

   // A RUN cycle that is not stalled; only these cycles act on decoder inputs.
   assign advance = (state_q == RUN) && !bus.Stall;

   // State register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.Start)          state_d = ARMED;
         ARMED:   if (!bus.Start)         state_d = RUN;
         RUN:     if (advance && bus.Ack) state_d = HALT;
         HALT:    if (bus.Start)          state_d = ARMED;
         default:                         state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.Running = (state_q == RUN);
   end

   // Next PC: Ack > Jump > taken branch > increment. Arithmetic wraps mod 2^PC_W.
   always_comb begin
      pc_d = pc_q;
      unique case (state_q)
         IDLE, ARMED: pc_d = '0;
         RUN: begin
            if (advance && !bus.Ack) begin
               if (bus.Jump) begin
                  pc_d = jump_targ;
               end else if (bus.BranchEn && bus.Zero) begin
                  pc_d = pc_q + br_off;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         HALT:    if (bus.Start) pc_d = '0;
         default: pc_d = '0;
      endcase
   end

   // Done tracks the HALT state one edge later, i.e. it is the registered state.
   always_comb begin
      done_d = (state_d == HALT);
   end

   // Cycle counter: cleared on ARMED entry, saturating count of advancing cycles.
   always_comb begin
      ct_d = ct_q;
      if ((state_d == ARMED) && (state_q != ARMED)) begin
         ct_d = '0;
      end else if (advance && (ct_q != '1)) begin
         ct_d = ct_q + CT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pc_q   <= '0;
         done_q <= 1'b0;
         ct_q   <= '0;
      end else begin
         pc_q   <= pc_d;
         done_q <= done_d;
         ct_q   <= ct_d;
      end
   end

   assign bus.ProgCtr = pc_q;
   assign bus.Done    = done_q;
   assign bus.CycleCt = ct_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit for the 9-bit ISA core. It owns the program counter and consumes the control decoder's sequencing outputs (Jump, BranchEn, PCTarg, Ack) plus the ALU Zero flag, and produces the next instruction address for instruction ROM. It also implements the Start/Done program handshake with the testbench. A cycle counter is provided for performance reporting.

## Interface

Parameters:
- PC_W, 10: program counter width; instruction ROM depth is 2^PC_W.
- CT_W, 16: width of the run-cycle counter.

Ports:
- Clk  input  1  system clock; everything is rising-edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  program start request from the testbench; held high, then released.
- Stall  input  1  freezes the PC for the current cycle while in RUN.
- Jump  input  1  decoder: absolute jump.
- BranchEn  input  1  decoder: conditional relative branch.
- Zero  input  1  ALU zero flag; the branch condition.
- PCTarg  input  2  decoder: index into the target/offset LUT.
- Ack  input  1  decoder: end-of-program instruction.
- ProgCtr  output  PC_W  address to instruction ROM (registered).
- Running  output  1  high while in RUN (decoded from state).
- Done  output  1  program finished (registered).
- CycleCt  output  CT_W  count of non-stalled RUN cycles; saturating.

## Operation

- States:
  - IDLE: Start=1 -> ARMED.
  - ARMED: Start=0 -> RUN.
  - RUN: Ack=1 and Stall=0 -> HALT.
  - HALT: Start=1 -> ARMED.
- IDLE and ARMED:
  - ProgCtr forced to 0, Done=0.
  - Decoder inputs are ignored.
  - Entering ARMED clears CycleCt to 0.
- RUN with Stall=1:
  - ProgCtr holds; CycleCt holds.
  - All decoder inputs are ignored, Ack included.
- RUN with Stall=0: next PC chosen by priority.
  1. Ack: ProgCtr holds; go to HALT.
  2. Jump: ProgCtr <= kJumpTarg[PCTarg] (absolute).
  3. BranchEn & Zero: ProgCtr <= ProgCtr + sign-extended kBrOff[PCTarg].
  4. Otherwise: ProgCtr <= ProgCtr + 1.
- Arithmetic:
  - All PC arithmetic is modulo 2^PC_W; overflow and underflow wrap silently.
  - kBrOff is 8-bit two's complement.
- CycleCt increments once per non-stalled RUN cycle, including the Ack cycle. It saturates at all-ones.
- HALT:
  - Done=1, ProgCtr frozen, CycleCt frozen.
  - Start=1 -> ARMED: ProgCtr=0, Done=0, CycleCt=0.
- Reset (any time, including mid-RUN):
  - state=IDLE, ProgCtr=0, Done=0, CycleCt=0, Running=0.

## Timing

- ProgCtr, Done and CycleCt are registered.
- Next-state and next-PC logic is combinational from the inputs sampled in the same cycle. The decoder's inputs reflect ROM[ProgCtr] in that cycle, so there is zero added latency: one instruction per cycle.
- Release of Start at edge N: the state is RUN after edge N+1. ProgCtr=0 is fetched during that first RUN cycle.
- Done rises on the edge that samples Ack=1 in RUN.
- Done falls on the edge that samples Start=1 in HALT.
- Running is decoded from the state, so it has the same timing as the state register.
- Reset_n low clears all registers immediately, without a clock. Deassertion is synchronized externally.

## Structure

- Add to the shared package (definitions):
  - the state enum fetch_state_t {IDLE, ARMED, RUN, HALT};
  - kJumpTarg[0:3] = {0, 32, 64, 128};
  - kBrOff[0:3] = {+2, +4, -4, -16}.
- One sub-module, target_lut:
  - combinational lookup of PCTarg -> {jump target, sign-extended offset};
  - kept separate so the assembler team can regenerate it.
- Everything else goes in fetch_unit: the state register, PC register, next-PC mux and cycle counter.

## Test plan

- Reset mid-run: RUN at ProgCtr=0x025, CycleCt=37, pull Reset_n low between edges -> ProgCtr=0, CycleCt=0, Running=0, Done=0 immediately. After release, state is IDLE.
- Start handshake: Start high 3 cycles, then low -> ProgCtr stays 0 throughout ARMED. After release, ProgCtr follows 0,0,1,2,3 and Running rises one edge after the release edge.
- Jump priority: at ProgCtr=5, Jump=1, PCTarg=2, BranchEn=1, Zero=1 -> next ProgCtr=64.
- Branch wrap and condition:
  - at ProgCtr=5, BranchEn=1, PCTarg=3, Zero=1 -> next ProgCtr=1013;
  - same inputs with Zero=0 -> next ProgCtr=6.
- Ack and restart:
  - at ProgCtr=20, Ack=1, Jump=1 -> ProgCtr stays 20 and Done=1 after the edge;
  - Start=1 -> Done=0, ProgCtr=0, CycleCt=0.
- Stall and saturation:
  - Stall=1 with Ack=1 -> no HALT, PC held;
  - ProgCtr=1023 with no event -> next ProgCtr=0;
  - CycleCt forced near max -> holds at 0xFFFF.
